lsu_sram_bridge: RTL and testbench

- Load/store adapter between the single-cycle core's LSU request and the 32-bit SRAM controller (3-cycle read, 2-cycle write).
- Converts RISC-V byte/half/word accesses into word-aligned SRAM transactions with byte masks.
- Pulses the controller request, waits for its ack, and returns sign/zero-extended load data.
- Stalls the core while a transaction is in flight; a watchdog aborts a transaction that is never acknowledged.

---
 rtl/lsu_sram_bridge.sv | 175 +++++++++++++++++
 tb/tb_lsu_sram_bridge.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_bridge.sv
// Load/store bridge from the core LSU to the 32-bit SRAM controller.
// Aligns byte/half/word accesses into masked word transactions and extends load data.
module lsu_sram_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [2:0]  i_lsu_funct3,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [17:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic [3:0]  o_sram_bmask,
  output logic        o_sram_wren,
  output logic        o_sram_rden,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;

  logic        req;
  logic        req_store;
  size_t       req_size;
  logic        req_misaligned;
  logic        accept;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_bmask;

  logic [18:0] q_addr;
  logic        q_store;
  size_t       q_size;
  logic        q_unsigned;
  logic [31:0] q_wdata;
  logic [3:0]  q_bmask;
  logic [7:0]  wd_cnt;
  logic [31:0] ld_data;
  logic [31:0] ld_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        wd_expired;

  logic        unused_addr_hi;
  assign unused_addr_hi = ^i_lsu_addr[31:19];

  // Anything that is not b/h/bu/hu decodes as a word access.
  always_comb begin
    req       = i_lsu_wren | i_lsu_rden;
    req_store = i_lsu_wren;
    case (i_lsu_funct3[1:0])
      2'b00:   req_size = SZ_B;
      2'b01:   req_size = SZ_H;
      default: req_size = SZ_W;
    endcase
    req_misaligned = ((req_size == SZ_H) && i_lsu_addr[0]) ||
                     ((req_size == SZ_W) && (i_lsu_addr[1:0] != 2'b00));
    accept = (state == S_IDLE) && req && !req_misaligned;
  end

  always_comb begin
    lane_wdata = i_lsu_wdata;
    lane_bmask = 4'b1111;
    if (req_store) begin
      case (req_size)
        SZ_B: begin
          lane_wdata = {4{i_lsu_wdata[7:0]}};
          lane_bmask = 4'b0001 << i_lsu_addr[1:0];
        end
        SZ_H: begin
          lane_wdata = {2{i_lsu_wdata[15:0]}};
          lane_bmask = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_wdata = i_lsu_wdata;
          lane_bmask = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    rd_byte = i_sram_rdata[{q_addr[1:0], 3'b000} +: 8];
    rd_half = q_addr[1] ? i_sram_rdata[31:16] : i_sram_rdata[15:0];
    case (q_size)
      SZ_B:    ld_ext = {{24{~q_unsigned & rd_byte[7]}}, rd_byte};
      SZ_H:    ld_ext = {{16{~q_unsigned & rd_half[15]}}, rd_half};
      default: ld_ext = i_sram_rdata;
    endcase
  end

  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: begin
        if (i_sram_ack) begin
          state_next = S_DONE;
        end else if (wd_expired) begin
          state_next = S_IDLE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields are frozen at accept so the controller sees stable values until the ack.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      q_addr     <= '0;
      q_store    <= 1'b0;
      q_size     <= SZ_B;
      q_unsigned <= 1'b0;
      q_wdata    <= '0;
      q_bmask    <= '0;
      wd_cnt     <= '0;
      ld_data    <= '0;
    end else begin
      if (accept) begin
        q_addr     <= i_lsu_addr[18:0];
        q_store    <= req_store;
        q_size     <= req_size;
        q_unsigned <= i_lsu_funct3[2];
        q_wdata    <= lane_wdata;
        q_bmask    <= lane_bmask;
      end
      if (state == S_REQ) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if ((state == S_WAIT) && i_sram_ack && !q_store) begin
        ld_data <= ld_ext;
      end
    end
  end

  always_comb begin
    o_stall      = accept || (state == S_REQ) || (state == S_WAIT);
    o_done       = (state == S_DONE);
    o_misaligned = (state == S_IDLE) && req && req_misaligned;
    o_timeout    = (state == S_WAIT) && !i_sram_ack && wd_expired;
    o_sram_wren  = (state == S_REQ) && q_store;
    o_sram_rden  = (state == S_REQ) && !q_store;
    o_sram_addr  = {q_addr[18:2], 1'b0};
    o_sram_wdata = q_wdata;
    o_sram_bmask = q_bmask;
    o_ld_data    = ld_data;
  end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Self-checking bench for lsu_sram_bridge: directed scenarios plus random traffic
// against an arithmetic reference model and a behavioural SRAM controller.
module tb_lsu_sram_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_funct3;
  logic        lsu_wren;
  logic        lsu_rden;
  logic [31:0] o_ld_data;
  logic        o_stall;
  logic        o_done;
  logic        o_misaligned;
  logic        o_timeout;
  logic [17:0] o_sram_addr;
  logic [31:0] o_sram_wdata;
  logic [3:0]  o_sram_bmask;
  logic        o_sram_wren;
  logic        o_sram_rden;
  logic [31:0] sram_rdata;
  logic        sram_ack;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_sram_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_lsu_addr   (lsu_addr),
    .i_lsu_wdata  (lsu_wdata),
    .i_lsu_funct3 (lsu_funct3),
    .i_lsu_wren   (lsu_wren),
    .i_lsu_rden   (lsu_rden),
    .o_ld_data    (o_ld_data),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_misaligned (o_misaligned),
    .o_timeout    (o_timeout),
    .o_sram_addr  (o_sram_addr),
    .o_sram_wdata (o_sram_wdata),
    .o_sram_bmask (o_sram_bmask),
    .o_sram_wren  (o_sram_wren),
    .o_sram_rden  (o_sram_rden),
    .i_sram_rdata (sram_rdata),
    .i_sram_ack   (sram_ack)
  );

  always #5 clk = ~clk;

  // Controller model: write acks 2 cycles after the request cycle, read 3; data only valid with ack.
  logic        ctrl_hold;
  logic [31:0] ctrl_rdata;
  int          ack_cd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_ack   <= 1'b0;
      sram_rdata <= '0;
      ack_cd     <= 0;
    end else begin
      sram_ack   <= 1'b0;
      sram_rdata <= ~ctrl_rdata;
      if (ack_cd == 1) begin
        sram_ack   <= 1'b1;
        sram_rdata <= ctrl_rdata;
      end
      if (ack_cd != 0) ack_cd <= ack_cd - 1;
      if (!ctrl_hold) begin
        if (o_sram_wren)      ack_cd <= 1;
        else if (o_sram_rden) ack_cd <= 2;
      end
    end
  end

  // Reference model helpers, derived from the access rules only.
  function automatic int ref_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [17:0] ref_addr(input logic [31:0] a);
    return 18'(((a % 32'h80000) / 4) * 2);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    if (ref_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
    if (ref_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] ref_bmask(input logic [31:0] a, input logic [2:0] f3, input bit st);
    if (!st) return 4'b1111;
    if (ref_size(f3) == 1) return 4'(1 << (a % 4));
    if (ref_size(f3) == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [2:0] f3);
    int     nb;
    int     sh;
    longint span;
    longint v;
    nb = ref_size(f3);
    if (nb == 4) return rdata;
    sh   = int'(a % 4) * 8;
    span = longint'(1) << (8 * nb);
    v    = longint'(rdata >> sh) % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  logic [31:0] last_ld;

  int          r_done_cyc;
  int          r_to_cyc;
  int          r_to_n;
  int          r_pulse_cyc;
  int          r_wren_n;
  int          r_rden_n;
  int          r_mis_n;
  int          r_stable_bad;
  logic [31:0] r_stall_mask;
  logic [31:0] r_ld;
  logic [17:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_bmask;
  logic        r_post_stall;
  logic [31:0] r_post_ld;

  // Drives one held request and records what the bridge does, cycle by cycle (cycle 0 = accept).
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic wr, input logic rd, input logic [31:0] rdata,
                         input bit hold, input bit mis);
    r_done_cyc = -1; r_to_cyc = -1; r_to_n = 0; r_pulse_cyc = -1;
    r_wren_n = 0; r_rden_n = 0; r_mis_n = 0; r_stable_bad = 0;
    r_stall_mask = '0; r_ld = '0; r_addr = '0; r_wdata = '0; r_bmask = '0;
    ctrl_rdata = rdata;
    ctrl_hold  = hold;
    @(negedge clk);
    lsu_addr = a; lsu_wdata = d; lsu_funct3 = f3; lsu_wren = wr; lsu_rden = rd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c < 32 && o_stall) r_stall_mask[c] = 1'b1;
      if (o_misaligned) r_mis_n++;
      if (r_pulse_cyc >= 0 && c > r_pulse_cyc && r_done_cyc < 0 &&
          {o_sram_addr, o_sram_wdata, o_sram_bmask} !== {r_addr, r_wdata, r_bmask})
        r_stable_bad++;
      if (o_sram_wren || o_sram_rden) begin
        r_pulse_cyc = c; r_addr = o_sram_addr; r_wdata = o_sram_wdata; r_bmask = o_sram_bmask;
      end
      if (o_sram_wren) r_wren_n++;
      if (o_sram_rden) r_rden_n++;
      if (o_done) begin r_done_cyc = c; r_ld = o_ld_data; end
      if (o_timeout) begin r_to_n++; if (r_to_cyc < 0) r_to_cyc = c; end
      if (o_done || o_timeout || (mis && c == 2)) break;
      @(negedge clk);
    end
    lsu_wren = 1'b0; lsu_rden = 1'b0;
    @(negedge clk);
    #1;
    r_post_stall = o_stall;
    r_post_ld    = o_ld_data;
    ctrl_hold    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; lsu_addr = '0; lsu_wdata = '0; lsu_funct3 = '0; lsu_wren = 0; lsu_rden = 0;
    ctrl_hold = 1'b0; ctrl_rdata = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({o_ld_data, o_stall, o_done, o_misaligned, o_timeout, o_sram_addr, o_sram_wdata,
         o_sram_bmask, o_sram_wren, o_sram_rden} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got ld=%h stall=%b done=%b addr=%h wdata=%h bmask=%h expected all 0",
               o_ld_data, o_stall, o_done, o_sram_addr, o_sram_wdata, o_sram_bmask);
    end
    @(negedge clk) rst_n = 1'b1;
    last_ld = '0;
  endtask

  task automatic test_store_word();
    run_txn(32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (r_wren_n !== 1 || r_rden_n !== 0 || r_pulse_cyc !== 1) begin
      n_fail++;
      $display("[TB] FAIL sw_pulse: got wren=%0d rden=%0d cyc=%0d expected 1 0 1", r_wren_n, r_rden_n, r_pulse_cyc);
    end
    n_checks++;
    if ({r_addr, r_bmask, r_wdata} !== {18'h00082, 4'b1111, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("[TB] FAIL sw_fields: got addr=%h bmask=%b wdata=%h expected 00082 1111 deadbeef", r_addr, r_bmask, r_wdata);
    end
    n_checks++;
    if (r_done_cyc !== 4) begin
      n_fail++; $display("[TB] FAIL sw_done_cycle: got %0d expected 4", r_done_cyc);
    end
    n_checks++;
    if (r_stall_mask !== 32'h0000_000F || r_post_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sw_stall: got mask=%h post=%b expected 0000000f 0", r_stall_mask, r_post_stall);
    end
    n_checks++;
    if (r_stable_bad !== 0) begin
      n_fail++; $display("[TB] FAIL sw_stable: got %0d unstable cycles expected 0", r_stable_bad);
    end
  endtask

  task automatic test_store_byte_then_load();
    run_txn(32'h0000_0103, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({r_wdata, r_bmask} !== {32'hA5A5_A5A5, 4'b1000} || r_done_cyc !== 4) begin
      n_fail++;
      $display("[TB] FAIL sb_lanes: got wdata=%h bmask=%b done=%0d expected a5a5a5a5 1000 4", r_wdata, r_bmask, r_done_cyc);
    end
    run_txn(32'h0000_0100, 32'h0, 3'b010, 1'b0, 1'b1, 32'hA500_0000, 1'b0, 1'b0);
    n_checks++;
    if (r_rden_n !== 1 || r_wren_n !== 0 || r_bmask !== 4'b1111 || r_addr !== 18'h00080) begin
      n_fail++;
      $display("[TB] FAIL lw_request: got rden=%0d wren=%0d bmask=%b addr=%h expected 1 0 1111 00080",
               r_rden_n, r_wren_n, r_bmask, r_addr);
    end
    n_checks++;
    if (r_ld !== 32'hA500_0000 || r_done_cyc !== 5) begin
      n_fail++; $display("[TB] FAIL lw_data: got %h at cycle %0d expected a5000000 at 5", r_ld, r_done_cyc);
    end
    n_checks++;
    if (r_stall_mask !== 32'h0000_001F) begin
      n_fail++; $display("[TB] FAIL lw_stall: got %h expected 0000001f", r_stall_mask);
    end
    last_ld = 32'hA500_0000;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [4];
    logic [31:0] adrs[4];
    logic [31:0] exps[4];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h103, 32'h103, 32'h102, 32'h102};
    exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      run_txn(adrs[i], 32'h0, f3s[i], 1'b0, 1'b1, 32'h80FF_7F01, 1'b0, 1'b0);
      n_checks++;
      if (r_ld !== exps[i] || r_done_cyc !== 5) begin
        n_fail++;
        $display("[TB] FAIL load_ext_%0d: got %h at cycle %0d expected %h at 5", i, r_ld, r_done_cyc, exps[i]);
      end
      last_ld = exps[i];
    end
    run_txn(32'h0000_0200, 32'h1234_5678, 3'b001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (r_post_ld !== last_ld || r_bmask !== 4'b0011 || r_wdata !== 32'h5678_5678) begin
      n_fail++;
      $display("[TB] FAIL sh_hold_ld: got ld=%h bmask=%b wdata=%h expected %h 0011 56785678",
               r_post_ld, r_bmask, r_wdata, last_ld);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] adrs[3];
    logic [2:0]  f3s [3];
    adrs = '{32'h102, 32'h101, 32'h203};
    f3s  = '{3'b010, 3'b001, 3'b101};
    for (int i = 0; i < 3; i++) begin
      run_txn(adrs[i], 32'hFFFF_FFFF, f3s[i], (i == 2) ? 1'b1 : 1'b0, (i == 2) ? 1'b0 : 1'b1,
              32'h0, 1'b0, 1'b1);
      n_checks++;
      if (r_mis_n !== 3 || r_stall_mask !== 32'h0 || (r_wren_n + r_rden_n) !== 0 || r_done_cyc !== -1) begin
        n_fail++;
        $display("[TB] FAIL misaligned_%0d: got mis=%0d stall=%h pulses=%0d done=%0d expected 3 0 0 -1",
                 i, r_mis_n, r_stall_mask, r_wren_n + r_rden_n, r_done_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    run_txn(32'h0000_0300, 32'h0, 3'b010, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
    n_checks++;
    if (r_to_cyc !== TIMEOUT + 1 || r_to_n !== 1 || r_done_cyc !== -1) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulse: got cycle=%0d count=%0d done=%0d expected %0d 1 -1",
               r_to_cyc, r_to_n, r_done_cyc, TIMEOUT + 1);
    end
    n_checks++;
    if (r_stall_mask !== 32'((64'd1 << (TIMEOUT + 2)) - 1) || r_post_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_stall: got mask=%h post=%b", r_stall_mask, r_post_stall);
    end
    n_checks++;
    if (r_post_ld !== last_ld) begin
      n_fail++; $display("[TB] FAIL timeout_ld_hold: got %h expected %h", r_post_ld, last_ld);
    end
  endtask

  task automatic test_reset_mid();
    ctrl_hold = 1'b1;
    ctrl_rdata = 32'h2222_2222;
    @(negedge clk);
    lsu_addr = 32'h0000_0400; lsu_funct3 = 3'b010; lsu_rden = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mid_stall: got %b expected 1", o_stall);
    end
    rst_n = 1'b0; lsu_rden = 1'b0;
    #1;
    n_checks++;
    if ({o_ld_data, o_stall, o_done, o_misaligned, o_timeout, o_sram_addr, o_sram_wdata,
         o_sram_bmask, o_sram_wren, o_sram_rden} !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: got ld=%h stall=%b addr=%h wdata=%h bmask=%h expected all 0",
               o_ld_data, o_stall, o_sram_addr, o_sram_wdata, o_sram_bmask);
    end
    @(negedge clk) rst_n = 1'b1;
    ctrl_hold = 1'b0;
    last_ld = '0;
    run_txn(32'h0000_0008, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (r_done_cyc !== 4 || r_wren_n !== 1 || r_wdata !== 32'hCAFE_F00D || r_post_ld !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_sw: got done=%0d wren=%0d wdata=%h ld=%h expected 4 1 cafef00d 0",
               r_done_cyc, r_wren_n, r_wdata, r_post_ld);
    end
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    int dones  [$];
    logic stall_at_done;
    stall_at_done = 1'b1;
    @(negedge clk);
    lsu_addr = 32'h0000_0010; lsu_wdata = 32'h0BAD_CAFE; lsu_funct3 = 3'b010; lsu_wren = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_sram_wren) pulses.push_back(c);
      if (o_done) begin dones.push_back(c); if (c == 4) stall_at_done = o_stall; end
      @(negedge clk);
    end
    lsu_wren = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pulses.size() !== 2 || dones.size() !== 2) begin
      n_fail++; $display("[TB] FAIL b2b_counts: got pulses=%0d dones=%0d expected 2 2", pulses.size(), dones.size());
    end else begin
      n_checks++;
      if (pulses[0] !== 1 || pulses[1] !== 6 || dones[0] !== 4 || dones[1] !== 9 || stall_at_done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL b2b_timing: got pulses %0d,%0d dones %0d,%0d stall=%b expected 1,6 4,9 0",
                 pulses[0], pulses[1], dones[0], dones[1], stall_at_done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic [2:0]  f3;
    logic        wr;
    logic        rd;
    bit          mis;
    int          sel;
    for (int i = 0; i < 60; i++) begin
      a     = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'(2 * $urandom_range(0, 1));
      d     = $urandom;
      rdata = $urandom;
      f3    = 3'($urandom_range(0, 7));
      sel   = $urandom_range(0, 2);
      wr    = (sel != 1);
      rd    = (sel != 0);
      mis   = ((a & 32'(ref_size(f3) - 1)) != 0);
      run_txn(a, d, f3, wr, rd, rdata, 1'b0, mis);
      if (mis) begin
        n_checks++;
        if (r_mis_n !== 3 || r_stall_mask !== 32'h0 || (r_wren_n + r_rden_n) !== 0) begin
          n_fail++;
          $display("[TB] FAIL rand_mis_%0d: got mis=%0d stall=%h pulses=%0d expected 3 0 0",
                   i, r_mis_n, r_stall_mask, r_wren_n + r_rden_n);
        end
      end else begin
        n_checks++;
        if (r_done_cyc !== (wr ? 4 : 5) || r_wren_n !== int'(wr) || r_rden_n !== int'(!wr) || r_pulse_cyc !== 1) begin
          n_fail++;
          $display("[TB] FAIL rand_timing_%0d: got done=%0d wren=%0d rden=%0d cyc=%0d for wr=%b",
                   i, r_done_cyc, r_wren_n, r_rden_n, r_pulse_cyc, wr);
        end
        n_checks++;
        if (r_addr !== ref_addr(a) || r_bmask !== ref_bmask(a, f3, wr) ||
            (wr && r_wdata !== ref_wdata(d, f3))) begin
          n_fail++;
          $display("[TB] FAIL rand_fields_%0d: got addr=%h bmask=%b wdata=%h expected %h %b %h",
                   i, r_addr, r_bmask, r_wdata, ref_addr(a), ref_bmask(a, f3, wr), ref_wdata(d, f3));
        end
        if (!wr) last_ld = ref_load(rdata, a, f3);
        n_checks++;
        if (r_post_ld !== last_ld || r_stable_bad !== 0 || r_post_stall !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rand_result_%0d: got ld=%h unstable=%0d post_stall=%b expected %h 0 0",
                   i, r_post_ld, r_stable_bad, r_post_stall, last_ld);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_then_load();
    test_load_ext();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation exceeded its time budget");
    $fatal(1, "[TB] time limit");
  end

endmodule
